regfile: RTL and testbench
==========================

Name: regfile

Overview:
- General-purpose register file for the OpenMIPS core: 32 x 32-bit, two read ports, one write port.
- Sits at the write-back end of the pipeline. It consumes the destination address, write-enable and result data that the execute stage produces (wd/wreg/wdata) once they have passed through mem/wb.
- It is also the read-side producer of reg1/reg2 operands for the decode stage.
- Register 0 is hard-wired to zero. A same-cycle write to a register being read is bypassed to the read port.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  input  1  clock; all writes on rising edge
rst  input  1  reset, asynchronous, active-low; clears all registers
we  input  1  write enable from write-back stage
waddr  input  ADDR_W  write register address
wdata  input  DATA_W  write data
re1  input  1  read enable, port 1
raddr1  input  ADDR_W  read address, port 1
rdata1  output  DATA_W  read data, port 1
re2  input  1  read enable, port 2
raddr2  input  ADDR_W  read address, port 2
rdata2  output  DATA_W  read data, port 2

Behaviour:
- Storage: NUM_REGS x DATA_W flops.
- Reset:
  - rst low clears every register to 0 immediately, without waiting for clk.
  - While rst is low, rdata1 = rdata2 = 0 regardless of any other input.
- Write:
  - On a rising clk with rst high, if we=1 and waddr!=0, then reg[waddr] <= wdata.
  - Writes to address 0 are discarded; reg[0] always reads 0.
  - we=0 means no state change.
- Read port n (n=1,2), combinational, evaluated in this priority order:
  1. rst low -> 0.
  2. raddrn==0 -> 0.
  3. ren=1 and we=1 and raddrn==waddr -> wdata. This is the write-through bypass, giving zero latency from write-back to decode.
  4. ren=1 -> reg[raddrn].
  5. ren=0 -> 0.
- Both ports are independent. Both may read the same address; both may bypass in the same cycle.
- Read latency is 0 cycles. A write becomes visible through storage from the cycle after the edge, and through the bypass in the same cycle.
- Reset mid-operation: a write pending on the same edge on which rst falls is lost. After rst rises, the first rising edge with we=1 writes normally.
- Reset release is synchronized externally; this block only requires rst to be deasserted glitch-free.
- There are no X outputs after reset: every path selects a defined value.

Test Plan:
- Reset: preload reg[5]=0x1234, pull rst low between edges -> rdata1 with re1=1, raddr1=5 reads 0 immediately. After release it still reads 0.
- Write/read: we=1, waddr=3, wdata=0xDEADBEEF, one edge, then we=0 -> re1=1, raddr1=3 gives 0xDEADBEEF; re2=1, raddr2=3 gives the same value.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF, edge -> raddr1=0 reads 0, including in the same cycle (no bypass for address 0).
- Bypass: reg[7]=0x11111111; in one cycle drive we=1, waddr=7, wdata=0x22222222 with re1=1, raddr1=7 -> rdata1=0x22222222 before the edge. After the edge, storage holds 0x22222222.
- Read enable off: reg[9]=0xABCD0000, re2=0, raddr2=9 -> rdata2=0. This also holds with we=1, waddr=9 (bypass is gated by re2).
- Sweep: write addr i with value i*0x01010101 for i=1..31, then read all pairs on both ports -> every read matches, and address 0 reads 0.

Source files
------------

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile: OpenMIPS general-purpose register file.
// 32 x 32-bit storage with one write port and two combinational read ports.
// Register 0 always reads zero. A write that is in flight this cycle is
// forwarded to any enabled read port that addresses the same register, so
// decode sees write-back results with zero latency.
// ----------------------------------------------------------------------------
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    // Architectural register storage; entry 0 is never written.
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Write qualifier: address 0 is hard-wired zero, so writes to it are dropped.
    logic w_wr_en;
    assign w_wr_en = we && (waddr != '0);

    // Values held in storage at each read address.
    logic [DATA_W-1:0] w_stored1;
    logic [DATA_W-1:0] w_stored2;
    assign w_stored1 = r_regs[raddr1];
    assign w_stored2 = r_regs[raddr2];

    // Read-port selection in priority order: reset, zero register, bypass of
    // the concurrent write, storage, and finally zero when the port is idle.
    function automatic logic [DATA_W-1:0] f_read_port(
        input logic              i_rst_n,
        input logic              i_re,
        input logic [ADDR_W-1:0] i_raddr,
        input logic              i_we,
        input logic [ADDR_W-1:0] i_waddr,
        input logic [DATA_W-1:0] i_wdata,
        input logic [DATA_W-1:0] i_stored
    );
        logic [DATA_W-1:0] v_out;
        v_out = '0;
        if (!i_rst_n) begin
            v_out = '0;
        end else if (i_raddr == '0) begin
            v_out = '0;
        end else if (i_re && i_we && (i_raddr == i_waddr)) begin
            v_out = i_wdata;
        end else if (i_re) begin
            v_out = i_stored;
        end else begin
            v_out = '0;
        end
        return v_out;
    endfunction

    // Storage update: asynchronous clear, then qualified write on the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Combinational read ports, each independent of the other.
    always_comb begin
        rdata1 = f_read_port(rst, re1, raddr1, we, waddr, wdata, w_stored1);
        rdata2 = f_read_port(rst, re2, raddr2, we, waddr, wdata, w_stored2);
    end

endmodule

// File: tb/tb_regfile.sv
// ----------------------------------------------------------------------------
// tb_regfile: self-checking bench for regfile.
// Table-driven vectors plus hand sequences for reset and a full sweep.
// Expected read values are queued when stimulus is applied and popped when
// the combinational outputs are sampled.
// ----------------------------------------------------------------------------
module tb_regfile;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    logic              clk;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    regfile #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re1   (re1),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .re2   (re2),
        .raddr2(raddr2),
        .rdata2(rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              re1;
        logic [ADDR_W-1:0] raddr1;
        logic              re2;
        logic [ADDR_W-1:0] raddr2;
        logic              edge_after;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Queue an expectation for the outputs currently being driven.
    task automatic expect_rd(input string name, input logic [DATA_W-1:0] e1,
                             input logic [DATA_W-1:0] e2);
        exp_t e;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        exp_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare both read ports against it.
    task automatic check_rd();
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = exp_q.pop_front();
        if (rdata1 !== e.e1) begin
            n_fail++;
            $display("FAIL %s rdata1: got %08h expected %08h", e.name, rdata1, e.e1);
        end
        n_tests++;
        if (rdata2 !== e.e2) begin
            n_fail++;
            $display("FAIL %s rdata2: got %08h expected %08h", e.name, rdata2, e.e2);
        end
    endtask

    task automatic drive(input logic w, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic r1,
                         input logic [ADDR_W-1:0] a1, input logic r2,
                         input logic [ADDR_W-1:0] a2);
        we     = w;
        waddr  = wa;
        wdata  = wd;
        re1    = r1;
        raddr1 = a1;
        re2    = r2;
        raddr2 = a2;
    endtask

    vec_t vecs[13];
    logic [DATA_W-1:0] model [NUM_REGS];

    // Watchdog: the bench must always terminate.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b1, 5'd0,  1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd3,  1'b0, 5'd3,  1'b1, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b1, 5'd3,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd3,  1'b0, 32'h0,        32'hDEADBEEF};
        vecs[5]  = '{1'b1, 5'd7,  32'h11111111, 1'b0, 5'd7,  1'b0, 5'd7,  1'b1, 32'h0,        32'h0};
        vecs[6]  = '{1'b1, 5'd7,  32'h22222222, 1'b1, 5'd7,  1'b1, 5'd3,  1'b1, 32'h22222222, 32'hDEADBEEF};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  1'b0, 32'h22222222, 32'h22222222};
        vecs[8]  = '{1'b1, 5'd9,  32'hABCD0000, 1'b1, 5'd9,  1'b0, 5'd9,  1'b1, 32'hABCD0000, 32'h0};
        vecs[9]  = '{1'b1, 5'd9,  32'h55555555, 1'b0, 5'd9,  1'b0, 5'd9,  1'b0, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 5'd9,  1'b0, 32'hABCD0000, 32'hABCD0000};
        vecs[11] = '{1'b1, 5'd12, 32'h0C0C0C0C, 1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 32'h0C0C0C0C, 32'h0C0C0C0C};
        vecs[12] = '{1'b1, 5'd13, 32'h00000001, 1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 32'h0C0C0C0C, 32'h00000001};

        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 5'd1, 1'b1, 5'd2);

        // Reset state: outputs are zero while reset is held.
        #2;
        expect_rd("reset_state", 32'h0, 32'h0);
        #1 check_rd();
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors: reads checked before the (optional) write edge.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].re1,
                  vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
            expect_rd($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2);
            #1 check_rd();
            if (!vecs[i].edge_after) we = 1'b0;
        end

        // Reset mid-operation: preload reg[5], then drop reset between edges.
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h00001234, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd12);
        expect_rd("preload5", 32'h00001234, 32'h0C0C0C0C);
        #1 check_rd();
        #1;
        rst = 1'b0;
        drive(1'b1, 5'd6, 32'hCAFEF00D, 1'b1, 5'd5, 1'b1, 5'd6);
        expect_rd("async_reset_immediate", 32'h0, 32'h0);
        #1 check_rd();
        @(negedge clk);
        expect_rd("reset_held_over_edge", 32'h0, 32'h0);
        #1 check_rd();
        we = 1'b0;
        rst = 1'b1;
        #1;
        expect_rd("after_release", 32'h0, 32'h0);
        #1 check_rd();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd3);
        expect_rd("cleared_others", 32'h0, 32'h0);
        #1 check_rd();
        @(negedge clk);
        drive(1'b1, 5'd6, 32'h600D600D, 1'b0, 5'd6, 1'b0, 5'd6);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 5'd5);
        expect_rd("first_write_after_reset", 32'h600D600D, 32'h0);
        #1 check_rd();

        // Sweep: write i*0x01010101 to every nonzero register, then read all pairs.
        model[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            @(negedge clk);
            model[i] = i * 32'h01010101;
            drive(1'b1, ADDR_W'(i), model[i], 1'b0, '0, 1'b0, '0);
        end
        @(negedge clk);
        we = 1'b0;
        re1 = 1'b1;
        re2 = 1'b1;
        for (int a = 0; a < NUM_REGS; a++) begin
            for (int b = 0; b < NUM_REGS; b++) begin
                raddr1 = ADDR_W'(a);
                raddr2 = ADDR_W'(b);
                expect_rd($sformatf("sweep_%0d_%0d", a, b), model[a], model[b]);
                #1 check_rd();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
